// File: rtl/dec5t32_en.sv
// Registered 5-to-32 one-hot decoder with active-high enable.
// Ports: clk, rst (async, active-high), I[4:0], En -> Y[31:0], Y_next[31:0], Valid.
module dec5t32_en #(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  I,
  input  logic        En,
  output logic [31:0] Y,
  output logic [31:0] Y_next,
  output logic        Valid
);

  localparam logic [31:0] INACT = OUT_ACTIVE_LOW ? 32'hFFFF_FFFF : 32'h0;

  logic [31:0] onehot_d;
  logic        valid_q;

  // En=0 leaves every line inactive whatever I holds.
  always_comb begin
    onehot_d = 32'h0;
    if (En) onehot_d[I] = 1'b1;
  end

  assign Y_next = OUT_ACTIVE_LOW ? ~onehot_d : onehot_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= En;
  end

  assign Valid = valid_q;

  generate
    if (REGISTERED) begin : g_reg
      logic [31:0] y_q;

      // Whole-word capture: never a mixed or two-hot value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= INACT;
        else     y_q <= Y_next;
      end

      assign Y = y_q;
    end else begin : g_comb
      assign Y = Y_next;
    end
  endgenerate

endmodule

// File: tb/tb_dec5t32_en.sv
// Scoreboard bench for dec5t32_en: default, active-low and
// combinational variants driven from shared inputs.
module tb_dec5t32_en;

  logic        clk;
  logic        rst;
  logic [4:0]  I;
  logic        En;
  logic [31:0] ya, yna, yb, ynb, yc, ync;
  logic        va, vb, vc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] ya;
    logic        va;
    logic [31:0] yb;
    logic        vb;
    logic        vc;
    int          tag;
  } exp_t;

  exp_t q[$];

  dec5t32_en #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) u_a (
    .clk(clk), .rst(rst), .I(I), .En(En),
    .Y(ya), .Y_next(yna), .Valid(va)
  );

  dec5t32_en #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) u_b (
    .clk(clk), .rst(rst), .I(I), .En(En),
    .Y(yb), .Y_next(ynb), .Valid(vb)
  );

  dec5t32_en #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) u_c (
    .clk(clk), .rst(rst), .I(I), .En(En),
    .Y(yc), .Y_next(ync), .Valid(vc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  int tagc = 0;

  // Called at posedge+2: drive, check comb paths, queue the registered result.
  task automatic step(input logic [4:0] i, input logic en,
                      input logic [31:0] exp);
    exp_t e;
    I  = i;
    En = en;
    #1;
    chk("ynext_a", tagc, yna, exp);
    chk("ynext_b", tagc, ynb, ~exp);
    chk("y_comb", tagc, yc, exp);
    e.ya  = exp;
    e.va  = en;
    e.yb  = ~exp;
    e.vb  = en;
    e.vc  = en;
    e.tag = tagc;
    q.push_back(e);
    tagc++;
    @(posedge clk);
    #2;
  endtask

  // Monitor: one registered output word per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("y_a", e.tag, ya, e.ya);
        chk("valid_a", e.tag, {31'b0, va}, {31'b0, e.va});
        chk("y_b", e.tag, yb, e.yb);
        chk("valid_b", e.tag, {31'b0, vb}, {31'b0, e.vb});
        chk("valid_c", e.tag, {31'b0, vc}, {31'b0, e.vc});
        if (e.va)
          chk("ones_a", e.tag, $countones(ya), 32'd1);
      end
    end
  end

  task automatic drain;
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    n_vec++;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    I   = 5'd0;
    En  = 1'b0;
    #1;
    chk("rst_y_a", 0, ya, 32'h0);
    chk("rst_v_a", 0, {31'b0, va}, 32'h0);
    chk("rst_y_b", 0, yb, 32'hFFFF_FFFF);
    chk("rst_v_c", 0, {31'b0, vc}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    step(5'd5, 1'b1, 32'h0000_0020);
    @(posedge clk);
    #1;
    #1;
    // Hold I=5/En=1, then reset mid-cycle with a live selection.
    I  = 5'd5;
    En = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("amid_y_a", 1, ya, 32'h0);
    chk("amid_v_a", 1, {31'b0, va}, 32'h0);
    chk("amid_y_b", 1, yb, 32'hFFFF_FFFF);
    chk("amid_v_b", 1, {31'b0, vb}, 32'h0);
    chk("amid_ynext", 1, yna, 32'h0000_0020);
    @(posedge clk);
    #1;
    chk("hold_y_a", 2, ya, 32'h0);
    chk("hold_v_a", 2, {31'b0, va}, 32'h0);
    #1;
    rst = 1'b0;
    step(5'd5, 1'b1, 32'h0000_0020);

    step(5'd0,  1'b1, 32'h0000_0001);
    step(5'd1,  1'b1, 32'h0000_0002);
    step(5'd2,  1'b1, 32'h0000_0004);
    step(5'd3,  1'b1, 32'h0000_0008);
    step(5'd4,  1'b1, 32'h0000_0010);
    step(5'd5,  1'b1, 32'h0000_0020);
    step(5'd6,  1'b1, 32'h0000_0040);
    step(5'd7,  1'b1, 32'h0000_0080);
    step(5'd8,  1'b1, 32'h0000_0100);
    step(5'd9,  1'b1, 32'h0000_0200);
    step(5'd10, 1'b1, 32'h0000_0400);
    step(5'd11, 1'b1, 32'h0000_0800);
    step(5'd12, 1'b1, 32'h0000_1000);
    step(5'd13, 1'b1, 32'h0000_2000);
    step(5'd14, 1'b1, 32'h0000_4000);
    step(5'd15, 1'b1, 32'h0000_8000);

    for (int k = 16; k < 32; k++)
      step(5'(k), 1'b0, 32'h0);

    step(5'd31, 1'b1, 32'h8000_0000);
    step(5'd31, 1'b0, 32'h0);
    step(5'd16, 1'b1, 32'h0001_0000);
    step(5'd23, 1'b1, 32'h0080_0000);
    step(5'd3,  1'b1, 32'h0000_0008);
    step(5'd3,  1'b0, 32'h0);
    step(5'd10, 1'b1, 32'h0000_0400);
    step(5'd0,  1'b0, 32'h0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dec5t32_en.md
Name: dec5t32_en

Overview:
- Registered 5-to-32 one-hot decoder with active-high enable.
- Used for address, register-file write-select and chip-select generation, where a 5-bit index must drive exactly one of 32 select lines, or none.
- The output is registered, so downstream logic sees glitch-free selects one clock after the index and enable are sampled.

Parameters:
- OUT_ACTIVE_LOW, 0: when 1, inverts every bit of Y and Y_next; selected line is 0, all others 1.
- REGISTERED, 1: when 1, Y is driven from a register (1-cycle latency); when 0, Y equals Y_next combinationally and clk/rst affect only Valid.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- I  input  5  index of the line to select, 0..31.
- En  input  1  decoder enable, active-high.
- Y  output  32  decoded select lines, registered per REGISTERED.
- Y_next  output  32  combinational decode of current I/En, same polarity as Y.
- Valid  output  1  registered copy of En; high when Y holds an active selection.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Combinational decode, with OUT_ACTIVE_LOW=0:
  - Y_next[k] = 1 when En=1 and I==k, for k=0..31; else 0.
  - En=0 forces Y_next to 32'h0000_0000 regardless of I.
- With OUT_ACTIVE_LOW=1, Y_next is the bitwise inverse of the above; the disabled value is 32'hFFFF_FFFF.
- One-hot guarantee: when En=1, exactly one bit of Y_next is at the active level for every I value. All 32 codes are legal, so there is no out-of-range case.
- Register path (REGISTERED=1):
  - On each rising clk with rst=0: Y <= Y_next and Valid <= En.
  - Latency is exactly 1 cycle from I/En sampling to Y.
- Combinational path (REGISTERED=0):
  - Y = Y_next with zero latency.
  - Valid is still registered (1-cycle latency).
- Reset:
  - rst=1 immediately, without waiting for clk, forces Y to its inactive value (32'h0 for active-high, 32'hFFFF_FFFF for active-low) and Valid to 0.
  - Applies to the Y register only when REGISTERED=1.
  - Outputs hold these values while rst is high.
  - On the first rising clk after rst deasserts, normal capture resumes.
  - Y_next is unaffected by rst.
- Reset mid-operation: asserting rst on any cycle discards the pending selection. No stale one-hot value may appear after reset release until a new capture occurs.
- Simultaneous I and En change: both are sampled on the same edge, so Y reflects the pair as sampled. The register may never hold a mixed or two-hot value.
- Unknown inputs: X/Z on I with En=1 may propagate X. En=0 must still force the inactive value regardless of I.
- No internal state other than the Y register (when REGISTERED=1) and the Valid flop.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with En=1, I=5 -> Y=32'h0 and Valid=0 immediately. Release rst, hold I=5, En=1; after the next rising edge -> Y=32'h0000_0020, Valid=1.
- Enabled sweep: En=1, I stepped 0..15, one value per cycle -> one cycle later Y = 1<<I (I=0 -> 32'h0000_0001, I=15 -> 32'h0000_8000), Valid=1, $countones(Y)==1 every cycle.
- Disabled sweep: En=0, I stepped 16..31 -> Y=32'h0 and Valid=0 one cycle later. Y_next=32'h0 throughout, including I=31.
- Boundary and enable toggle: En=1, I=31 -> Y=32'h8000_0000. On the next cycle drop En with I unchanged -> Y=32'h0 one cycle later.
- Parameter variants:
  - OUT_ACTIVE_LOW=1, En=1, I=3 -> Y=32'hFFFF_FFF7; En=0 -> Y=32'hFFFF_FFFF; reset -> 32'hFFFF_FFFF.
  - REGISTERED=0, I=10, En=1 -> Y=32'h0000_0400 in the same cycle, with Valid rising one cycle later.
